// File: rtl/toggle_handshake_tx.sv
// Source side of a two-phase toggle handshake: queues event pulses and launches one req_o toggle per ack.
// Optional ack-timeout flag is built only when TOGGLE_HS_TX_TIMEOUT_EN is defined.
module toggle_handshake_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             pulse_i,
  output logic             req_o,
  input  logic             ack_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             done_o,
  output logic             drop_o,
  output logic             err_o
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("toggle_handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   req_q;
  logic                   done_q;
  logic                   drop_q;
  logic [CNT_W-1:0]       pend_q;

  logic ack_s;
  logic complete;
  logic can_launch;
  logic launch;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s      = ack_sync_q[SYNC_STAGES-1];
  assign complete   = (state_q == ST_WAIT_ACK) && (ack_s == req_q);
  assign can_launch = (state_q == ST_IDLE) || complete;
  assign launch     = can_launch && (pulse_i || (pend_q != '0));

  // A launch consumes pulse_i first; only a launch without pulse_i drains the queue.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      done_q <= complete;
      drop_q <= pulse_i && !launch && (pend_q == PEND_MAX);
      if (launch) begin
        req_q   <= ~req_q;
        state_q <= ST_WAIT_ACK;
      end else if (complete) begin
        state_q <= ST_IDLE;
      end
      if (pulse_i && !launch && (pend_q != PEND_MAX)) begin
        pend_q <= pend_q + PEND_ONE;
      end else if (launch && !pulse_i) begin
        pend_q <= pend_q - PEND_ONE;
      end
    end
  end

`ifdef TOGGLE_HS_TX_TIMEOUT_EN
  localparam int             TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // err_q rises on the edge where the wait counter reaches TIMEOUT; the FSM keeps waiting.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (launch) begin
        tmo_q <= '0;
      end else if ((state_q == ST_WAIT_ACK) && (tmo_q != TMO_MAX)) begin
        tmo_q <= tmo_q + TMO_ONE;
        if (tmo_q == TMO_LAST) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign req_o     = req_q;
  assign busy_o    = (state_q == ST_WAIT_ACK);
  assign pending_o = pend_q;
  assign done_o    = done_q;
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
// Directed bench for toggle_handshake_tx: looped-back remote model with 3-cycle delay,
// a second small-queue instance for overflow; timeout checks follow TOGGLE_HS_TX_TIMEOUT_EN.
module tb_toggle_handshake_tx;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       pulse = 1'b0;
  logic       ack = 1'b0;
  logic       req, busy, done, drop, err;
  logic [3:0] pending;

  logic       pulse2 = 1'b0;
  logic       ack2 = 1'b0;
  logic       req2, busy2, done2, drop2, err2;
  logic [1:0] pending2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] pipe = '0;
  logic       loop_en = 1'b0;
  logic       req_prev = 1'b0;
  logic       req_chg = 1'b0;
  int         tog_cnt = 0;
  int         done_cnt = 0;
  int         drop2_cnt = 0;

  always #5 clk = ~clk;

  toggle_handshake_tx #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(16)) u_dut (
    .clk_i(clk), .arst_n_i(arst_n), .pulse_i(pulse), .req_o(req), .ack_i(ack),
    .busy_o(busy), .pending_o(pending), .done_o(done), .drop_o(drop), .err_o(err)
  );

  toggle_handshake_tx #(.CNT_W(2), .SYNC_STAGES(2), .TIMEOUT(16)) u_dut_small (
    .clk_i(clk), .arst_n_i(arst_n), .pulse_i(pulse2), .req_o(req2), .ack_i(ack2),
    .busy_o(busy2), .pending_o(pending2), .done_o(done2), .drop_o(drop2), .err_o(err2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample #1 after the edge, then advance the remote loopback model.
  task automatic cyc();
    @(posedge clk);
    #1;
    pipe = {pipe[1:0], req};
    if (loop_en) ack = pipe[2];
    req_chg = (req != req_prev);
    if (req_chg) tog_cnt++;
    req_prev = req;
    if (done) done_cnt++;
    if (drop2) drop2_cnt++;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!done && lat <= limit);
  endtask

  int lat;
  int gap;
  int done_tog;
  int guard;
  logic seen;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_done_drop_err", {done, drop, err}, 0);
    arst_n = 1'b1;

    // single event, ack looped back
    loop_en = 1'b1;
    repeat (4) cyc();
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    check_eq("single_req", req, 1);
    check_eq("single_busy", busy, 1);
    check_eq("single_pending", pending, 0);
    wait_done(20, lat);
    check_eq("single_ack_latency", lat, 5);
    check_eq("single_idle_after_done", busy, 0);
    cyc();
    check_eq("single_done_one_cycle", done, 0);
    check_eq("single_final_pending", pending, 0);

    // pulse coincident with completion, empty queue
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    check_eq("simul_first_req", req, 0);
    repeat (4) cyc();
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    check_eq("simul_done", done, 1);
    check_eq("simul_req_toggled", req, 1);
    check_eq("simul_busy", busy, 1);
    check_eq("simul_pending", pending, 0);
    wait_done(20, lat);
    check_eq("simul_second_latency", lat, 5);
    cyc();

    // burst of 5 with ack held off, then released
    loop_en = 1'b0;
    tog_cnt = 0;
    done_cnt = 0;
    pulse = 1'b1;
    repeat (5) cyc();
    pulse = 1'b0;
    check_eq("burst_pending", pending, 4);
    check_eq("burst_one_launch", tog_cnt, 1);
    loop_en = 1'b1;
    gap = 0;
    done_tog = 0;
    guard = 0;
    while (done_cnt < 5 && guard < 100) begin
      cyc();
      guard++;
      if (done && req_chg) done_tog++;
      if (!busy && done_cnt < 5) gap++;
    end
    check_eq("burst_done_count", done_cnt, 5);
    check_eq("burst_toggle_count", tog_cnt, 5);
    check_eq("burst_no_idle_gap", gap, 0);
    check_eq("burst_b2b_toggles", done_tog, 4);
    cyc();
    check_eq("burst_end_busy", busy, 0);
    check_eq("burst_end_pending", pending, 0);

    // overflow on the CNT_W=2 instance, ack stuck low
    drop2_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      pulse2 = 1'b1;
      cyc();
      check_eq($sformatf("ovf_drop_c%0d", i), drop2, (i == 4) ? 1 : 0);
    end
    pulse2 = 1'b0;
    cyc();
    check_eq("ovf_pending", pending2, 3);
    check_eq("ovf_req", req2, 1);
    check_eq("ovf_drop_clears", drop2, 0);
    repeat (3) cyc();
    check_eq("ovf_drop_count", drop2_cnt, 1);

    // reset mid-flight
    loop_en = 1'b0;
    pulse = 1'b1;
    repeat (3) cyc();
    pulse = 1'b0;
    check_eq("mrst_pre_busy", busy, 1);
    check_eq("mrst_pre_pending", pending, 2);
    #2;
    arst_n = 1'b0;
    #1;
    check_eq("mrst_req", req, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_pending", pending, 0);
    check_eq("mrst_flags", {done, drop, err}, 0);
    check_eq("mrst_small_pending", pending2, 0);
    pipe = '0;
    ack = 1'b0;
    req_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    loop_en = 1'b1;
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    check_eq("mrst_resume_req", req, 1);
    wait_done(20, lat);
    check_eq("mrst_resume_latency", lat, 5);
    cyc();

`ifdef TOGGLE_HS_TX_TIMEOUT_EN
    check_eq("tmo_clear_before", err, 0);
    loop_en = 1'b0;
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    repeat (15) cyc();
    check_eq("tmo_not_yet", err, 0);
    cyc();
    check_eq("tmo_set", err, 1);
    repeat (5) cyc();
    check_eq("tmo_sticky", err, 1);
    check_eq("tmo_still_waiting", busy, 1);
    loop_en = 1'b1;
    wait_done(20, lat);
    seen = (lat <= 20);
    check_eq("tmo_late_ack_done", seen, 1);
    cyc();
    check_eq("tmo_sticky_after_done", err, 1);
`else
    loop_en = 1'b0;
    pulse = 1'b1;
    cyc();
    pulse = 1'b0;
    repeat (40) cyc();
    check_eq("no_tmo_err_low", err, 0);
    check_eq("no_tmo_still_busy", busy, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
